// File: rtl/jtframe_credits_pkg.sv
// Shared types and constants for the credits overlay controller.
// Holds the sequencer state encoding and overlay control bit layout.
package jtframe_credits_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHOW,
    ST_HIDDEN
  } cr_state_e;

  localparam logic [7:0] CR_CLRCHAR = 8'h20;

  localparam int CR_EN   = 0;
  localparam int CR_TOG  = 1;
  localparam int CR_FAST = 2;
  localparam int CR_W    = 3;

endpackage

// File: rtl/jtframe_credits_arb.sv
// Two-way fixed-priority VRAM write arbiter with registered grant.
// A forced owner (the clear sweep) pre-empts both requesters.
module jtframe_credits_arb
  import jtframe_credits_pkg::*;
#(
  parameter int AW = 10
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_req_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [7:0]    ld_din_i,
  output logic          ld_ack_o,
  input  logic          gm_req_i,
  input  logic [AW-1:0] gm_addr_i,
  input  logic [7:0]    gm_din_i,
  output logic          gm_ack_o,
  input  logic          frc_i,
  input  logic [AW-1:0] frc_addr_i,
  input  logic [7:0]    frc_din_i,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [7:0]    din_o
);

  logic          ld_win, gm_win;
  logic          ld_ack_q, ld_ack_d;
  logic          gm_ack_q, gm_ack_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    din_q, din_d;

  // An acked side sits out its ack cycle, so gm always fits in between.
  assign ld_win = ~frc_i & ld_req_i & ~ld_ack_q;
  assign gm_win = ~frc_i & ~ld_win & gm_req_i & ~gm_ack_q;

  always_comb begin
    we_d     = 1'b1;
    ld_ack_d = 1'b0;
    gm_ack_d = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    unique case (1'b1)
      frc_i: begin
        addr_d = frc_addr_i;
        din_d  = frc_din_i;
      end
      ld_win: begin
        ld_ack_d = 1'b1;
        addr_d   = ld_addr_i;
        din_d    = ld_din_i;
      end
      gm_win: begin
        gm_ack_d = 1'b1;
        addr_d   = gm_addr_i;
        din_d    = gm_din_i;
      end
      default: we_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ack_q <= 1'b0;
      gm_ack_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      ld_ack_q <= ld_ack_d;
      gm_ack_q <= gm_ack_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  assign ld_ack_o = ld_ack_q;
  assign gm_ack_o = gm_ack_q;
  assign we_o     = we_q;
  assign addr_o   = addr_q;
  assign din_o    = din_q;

endmodule

// File: rtl/jtframe_credits_ctrl.sv
// Credits overlay sequencer: show/hide/timeout control, VRAM clear
// sweep and ownership of the overlay VRAM write port.
module jtframe_credits_ctrl
  import jtframe_credits_pkg::*;
#(
  parameter int         AW      = 10,
  parameter logic [7:0] CLRCHAR = CR_CLRCHAR,
  parameter int         TOW     = 10,
  parameter int         TIMEOUT = 600
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vb,
  input  logic          pause,
  input  logic          skip,
  input  logic          clr,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_din,
  output logic          ld_ack,
  input  logic          gm_req,
  input  logic [AW-1:0] gm_addr,
  input  logic [7:0]    gm_din,
  output logic          gm_ack,
  output logic [AW-1:0] vram_addr,
  output logic [7:0]    vram_din,
  output logic          vram_we,
  output logic          cr_enable,
  output logic          cr_toggle,
  output logic          fast_scroll,
  output logic          busy
);

  localparam logic [AW-1:0]  LAST    = '1;
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);
  localparam bit             TO_EN   = (TIMEOUT != 0);

  cr_state_e       st_q, st_d;
  logic            pause_q, skip_q, vb_q;
  logic [TOW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]   caddr_q, caddr_d;
  logic [CR_W-1:0] ctl_q, ctl_d;
  logic            busy_q, busy_d;
  logic            prise, pfall, srise, vrise, tmo;
  logic            clr_go, sweep;

  assign prise = pause & ~pause_q;
  assign pfall = ~pause & pause_q;
  assign srise = skip & ~skip_q;
  assign vrise = vb & ~vb_q;
  assign tmo   = TO_EN && vrise && (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      pause_q <= 1'b0;
      skip_q  <= 1'b0;
      vb_q    <= 1'b0;
      cnt_q   <= '0;
      caddr_q <= '0;
      ctl_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      pause_q <= pause;
      skip_q  <= skip;
      vb_q    <= vb;
      cnt_q   <= cnt_d;
      caddr_q <= caddr_d;
      ctl_q   <= ctl_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE: begin
        if (prise)    st_d = ST_SHOW;
        else if (clr) st_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (caddr_q == LAST) st_d = ST_IDLE;
      end
      ST_SHOW: begin
        if (pfall)    st_d = ST_IDLE;
        else if (tmo) st_d = ST_HIDDEN;
      end
      ST_HIDDEN: begin
        if (pfall)      st_d = ST_IDLE;
        else if (srise) st_d = ST_SHOW;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // The sweep owns the port from the cycle clr is taken.
  always_comb begin
    clr_go  = (st_q == ST_IDLE) & ~prise & clr;
    sweep   = clr_go | (st_q == ST_CLEAR);
    caddr_d = sweep ? caddr_q + 1'b1 : caddr_q;
    cnt_d   = '0;
    if (st_q == ST_SHOW && st_d == ST_SHOW)
      cnt_d = (vrise && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    ctl_d          = '0;
    ctl_d[CR_EN]   = (st_d == ST_SHOW) || (st_d == ST_HIDDEN);
    ctl_d[CR_TOG]  = (st_q == ST_SHOW && st_d == ST_HIDDEN) ||
                     (st_q == ST_HIDDEN && st_d == ST_SHOW);
    ctl_d[CR_FAST] = skip && st_q == ST_SHOW && st_d == ST_SHOW;
    busy_d         = sweep;
  end

  jtframe_credits_arb #(.AW(AW)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_req_i  (ld_req),
    .ld_addr_i (ld_addr),
    .ld_din_i  (ld_din),
    .ld_ack_o  (ld_ack),
    .gm_req_i  (gm_req),
    .gm_addr_i (gm_addr),
    .gm_din_i  (gm_din),
    .gm_ack_o  (gm_ack),
    .frc_i     (sweep),
    .frc_addr_i(caddr_q),
    .frc_din_i (CLRCHAR),
    .we_o      (vram_we),
    .addr_o    (vram_addr),
    .din_o     (vram_din)
  );

  assign cr_enable   = ctl_q[CR_EN];
  assign cr_toggle   = ctl_q[CR_TOG];
  assign fast_scroll = ctl_q[CR_FAST];
  assign busy        = busy_q;

endmodule

// File: doc/jtframe_credits_ctrl.md
Name: jtframe_credits_ctrl

Overview:
- Sequences the credits overlay and owns its VRAM write port.
- Drives the overlay's enable, toggle and fast_scroll controls from the pause/skip buttons, a frame-based auto-hide timeout and a clear command.
- Arbitrates VRAM writes between the download loader and a game-side status writer.
- Sits between the framework's input/download logic and the credits overlay.

Parameters:
- AW, 10: VRAM address width; clear sweeps 2^AW locations.
- CLRCHAR, 8'h20: byte written to every location by a clear.
- TOW, 10: frame-counter width.
- TIMEOUT, 600: frames in SHOW before auto-hide; 0 disables auto-hide.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- vb  in  1  vertical blank, active high.
- pause  in  1  level; high = credits screen requested.
- skip  in  1  level; skip/unhide button.
- clr  in  1  one-cycle clear command.
- ld_req  in  1  loader write request.
- ld_addr  in  AW  loader address.
- ld_din  in  8  loader data.
- ld_ack  out  1  loader write accepted.
- gm_req  in  1  game write request.
- gm_addr  in  AW  game address.
- gm_din  in  8  game data.
- gm_ack  out  1  game write accepted.
- vram_addr  out  AW  overlay VRAM address.
- vram_din  out  8  overlay VRAM data.
- vram_we  out  1  overlay VRAM write strobe.
- cr_enable  out  1  overlay enable.
- cr_toggle  out  1  one-cycle overlay toggle pulse.
- fast_scroll  out  1  overlay fast scroll.
- busy  out  1  high while in CLEAR.

Behaviour:
- Reset (async, rst_n=0): every output 0, state IDLE, frame counter 0, clear address 0, edge registers 0.
- Edge detection: pause, skip and vb edges are detected against registered copies. All outputs are registered.
- FSM states:
  - IDLE: cr_enable=0.
    - pause rise -> SHOW.
    - clr=1 (with no pause rise) -> CLEAR.
    - pause rise and clr in the same cycle: pause wins; clr is dropped.
  - CLEAR: busy=1, cr_enable=0. Writes CLRCHAR to addresses 0..2^AW-1, one per cycle, vram_we=1 throughout. After address 2^AW-1 is written -> IDLE. pause and clr are ignored; a pause still high on exit is not an edge and does not start SHOW.
  - SHOW: cr_enable=1; frame counter increments on each vb rise.
    - Counter reaches TIMEOUT-1 and another vb rise arrives (TIMEOUT!=0): cr_toggle=1 for one cycle, counter cleared -> HIDDEN.
    - pause fall -> IDLE; takes priority over the timeout in the same cycle.
  - HIDDEN: cr_enable=1.
    - skip rise: cr_toggle=1 for one cycle, counter cleared -> SHOW.
    - pause fall -> IDLE, no toggle.
- fast_scroll = skip held AND state SHOW, registered; the skip rise that unhides does not assert fast_scroll until the next cycle in SHOW.
- Toggle pulses are never issued while cr_enable=0.
- Counter width: TOW bits, saturates at all-ones; TIMEOUT must be < 2^TOW.
- Arbitration (not in CLEAR):
  - Fixed priority, ld over gm. Requests are sampled in cycle N.
  - Cycle N+1: vram_we=1, vram_addr/vram_din = the winner's registered values, and the winner's ack=1.
  - A requester whose ack is high is ineligible that cycle. Its next write is granted no earlier than N+2, so each requester gets at most one write per 2 cycles.
  - The game therefore gets the slot in every loader ack cycle; a continuous loader cannot starve gm.
  - Requesters hold req/addr/din until their ack. A req still high in the ack cycle is treated as the next request.
  - No grants and no acks during CLEAR; pending requests wait.
  - Entering CLEAR while a grant is in flight: the in-flight write completes in that cycle, then the sweep starts on the next cycle.

Decomposition:
- Shared package/header jtframe_credits_pkg:
  - FSM state encoding: IDLE, CLEAR, SHOW, HIDDEN.
  - CLRCHAR default.
  - Overlay control bit positions.
- One sub-module, jtframe_credits_arb: 2-way fixed-priority write arbiter with ack and the ineligible-after-ack rule, plus a force-owner input used by CLEAR.

Test Plan:
- Reset mid-CLEAR at address 0x155 -> all outputs 0 immediately; after release state IDLE, no vram_we.
- clr in IDLE, AW=10 -> exactly 1024 consecutive vram_we, addr 0..0x3FF, data 0x20, busy high throughout, IDLE after.
- pause rise, TIMEOUT=3, 3 vb rises -> cr_enable=1; single cr_toggle pulse on the third vb rise. Then skip rise -> second cr_toggle, state SHOW. Then pause fall -> cr_enable=0.
- ld_req and gm_req held continuously for 8 cycles, with addr/din updated on each ack -> acks alternate ld,gm,ld,gm; vram_we high every cycle from N+1.
- clr while gm_req pending -> gm_ack withheld for 1024 cycles, then granted with the original gm_addr/gm_din.
- skip held in SHOW -> fast_scroll=1; enter HIDDEN via timeout -> fast_scroll=0 the next cycle.
